clock_counter: RTL

//   BCD time-of-day core for the digital clock. Divides clk to a 1 Hz tick, counts
//   HH:MM:SS (24 h, packed BCD) and lets the user set hours/minutes via two buttons.

---
 rtl/clock_counter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/clock_counter.sv
// Time-of-day core: divides clk to a 1 s tick and keeps packed-BCD HH:MM:SS (24 h).
// Two buttons step through RUN / SET_H / SET_M and increment the selected field.
module clock_counter #(
   parameter int unsigned CLK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [7:0] curHour,
   output logic [7:0] curMin,
   output logic [7:0] curSec,
   output logic [1:0] mode,
   output logic       sec_tick,
   output logic       hour_pulse
);

   localparam int unsigned    PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_SET_H = 2'd1;
   localparam logic [1:0] S_SET_M = 2'd2;

   logic [7:0]    r_hour, r_min, r_sec;
   logic [1:0]    r_mode;
   logic [PW-1:0] r_presc;
   logic          r_sec_tick, r_hour_pulse;
   logic          r_mode_q, r_inc_q;

   logic [7:0]    w_hour_nxt, w_min_nxt, w_sec_nxt;
   logic [1:0]    w_mode_nxt;
   logic [PW-1:0] w_presc_nxt;
   logic          w_sec_tick_nxt, w_hour_pulse_nxt;
   logic          w_mode_edge, w_inc_edge;

   // BCD increment for 00..59 fields, wrapping to 00
   function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
      if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
      if (v[7:4] >= 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
   endfunction

   // BCD increment for 00..23 hours, wrapping to 00
   function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
      if (v == 8'h23)     return 8'h00;
      if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
      return {v[7:4] + 4'd1, 4'd0};
   endfunction

   assign w_mode_edge = mode_btn & ~r_mode_q;
   assign w_inc_edge  = inc_btn  & ~r_inc_q;

   // Next-state: a mode edge always wins over a tick or an inc edge in the same cycle
   always_comb begin
      w_mode_nxt       = r_mode;
      w_hour_nxt       = r_hour;
      w_min_nxt        = r_min;
      w_sec_nxt        = r_sec;
      w_presc_nxt      = r_presc;
      w_sec_tick_nxt   = 1'b0;
      w_hour_pulse_nxt = 1'b0;
      case (r_mode)
         S_RUN: begin
            if (w_mode_edge) begin
               w_mode_nxt  = S_SET_H;
               w_sec_nxt   = 8'h00;
               w_presc_nxt = '0;
            end else if (r_presc == PRESC_MAX) begin
               w_presc_nxt    = '0;
               w_sec_tick_nxt = 1'b1;
               w_sec_nxt      = bcd_inc60(r_sec);
               if (r_sec == 8'h59) begin
                  w_min_nxt = bcd_inc60(r_min);
                  if (r_min == 8'h59) begin
                     w_hour_nxt       = bcd_inc24(r_hour);
                     w_hour_pulse_nxt = 1'b1;
                  end
               end
            end else begin
               w_presc_nxt = r_presc + PW'(1);
            end
         end
         S_SET_H: begin
            w_presc_nxt = '0;
            if (w_mode_edge)     w_mode_nxt = S_SET_M;
            else if (w_inc_edge) w_hour_nxt = bcd_inc24(r_hour);
         end
         S_SET_M: begin
            w_presc_nxt = '0;
            if (w_mode_edge)     w_mode_nxt = S_RUN;
            else if (w_inc_edge) w_min_nxt  = bcd_inc60(r_min);
         end
         default: begin
            w_mode_nxt  = S_RUN;
            w_presc_nxt = '0;
         end
      endcase
   end

   // Button history loads live levels in reset so a held button gives no edge on release
   always_ff @(posedge clk) begin
      r_mode_q <= mode_btn;
      r_inc_q  <= inc_btn;
      if (rst) begin
         r_hour       <= 8'h00;
         r_min        <= 8'h00;
         r_sec        <= 8'h00;
         r_mode       <= S_RUN;
         r_presc      <= '0;
         r_sec_tick   <= 1'b0;
         r_hour_pulse <= 1'b0;
      end else begin
         r_hour       <= w_hour_nxt;
         r_min        <= w_min_nxt;
         r_sec        <= w_sec_nxt;
         r_mode       <= w_mode_nxt;
         r_presc      <= w_presc_nxt;
         r_sec_tick   <= w_sec_tick_nxt;
         r_hour_pulse <= w_hour_pulse_nxt;
      end
   end

   assign curHour    = r_hour;
   assign curMin     = r_min;
   assign curSec     = r_sec;
   assign mode       = r_mode;
   assign sec_tick   = r_sec_tick;
   assign hour_pulse = r_hour_pulse;

endmodule
